// File: rtl/load_store_pkg.sv
// Shared encodings for the load/store stage: RISC-V funct3 codes, FSM states
// and the access-fault rule.
package load_store_pkg;

    localparam logic [2:0] LS_B = 3'b000;
    localparam logic [2:0] LS_H = 3'b001;
    localparam logic [2:0] LS_W = 3'b010;
    localparam int LS_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    // Size comes from funct3[1:0]; the unsigned bit is only meaningful on b/h loads.
    function automatic logic misaligned(input logic [2:0] funct3,
                                        input logic [1:0] addr,
                                        input logic       store);
        logic bad;
        case (funct3[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr != 2'b00) || funct3[LS_UNSIGNED_BIT];
            default: bad = 1'b1;
        endcase
        return bad || (store && funct3[LS_UNSIGNED_BIT]);
    endfunction

endpackage

// File: rtl/load_store32.sv
// Combinational lane logic: extracts and extends sub-word loads from a RAM
// word and merges sub-word store data into the word for read-modify-write.
module load_store32
    import load_store_pkg::*;
(
    input  logic [1:0]  address,
    input  logic [2:0]  funct3,
    input  logic [31:0] ram_read_value,
    input  logic [31:0] store_value,
    output logic [31:0] load_value,
    output logic [31:0] ram_store_value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  lane_mask;
    logic [31:0] store_rep;

    assign byte_sel = ram_read_value[8*address +: 8];
    assign half_sel = address[1] ? ram_read_value[31:16] : ram_read_value[15:0];

    always_comb begin
        load_value = '0;
        case (funct3)
            LS_B:          load_value = {{24{byte_sel[7]}}, byte_sel};
            LS_B | 3'b100: load_value = {24'd0, byte_sel};
            LS_H:          load_value = {{16{half_sel[15]}}, half_sel};
            LS_H | 3'b100: load_value = {16'd0, half_sel};
            LS_W:          load_value = ram_read_value;
            default:       load_value = '0;
        endcase
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   lane_mask = 4'b0001 << address;
            2'b01:   lane_mask = address[1] ? 4'b1100 : 4'b0011;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    end

    // Replicate the low bytes so any selected lane finds its data in place.
    assign store_rep = funct3[1] ? store_value :
                       funct3[0] ? {2{store_value[15:0]}} : {4{store_value[7:0]}};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign ram_store_value[8*gi +: 8] = lane_mask[gi] ? store_rep[8*gi +: 8]
                                                              : ram_read_value[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request at a time, alignment check, then read,
// read-modify-write or direct write of a word-addressed RAM port.
module load_store_unit
    import load_store_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_store,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [31:0]              req_store_value,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_efault,
    output logic [31:0]              resp_load_value,
    output logic [ADDRESS_WIDTH-3:0] ram_address,
    output logic                     ram_read_enable,
    output logic                     ram_write_enable,
    output logic [31:0]              ram_write_value,
    input  logic [31:0]              ram_read_value,
    input  logic                     ram_ack
);

    state_t      state;
    logic        store_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  offset_reg;
    logic [31:0] store_value_reg;
    logic [31:0] word_reg;

    logic        fault;
    logic [31:0] word_in;
    logic [31:0] load_value;
    logic [31:0] ram_store_value;

    assign fault     = misaligned(req_funct3, req_address[1:0], req_store);
    assign req_ready = (state == IDLE);

    // During READ the lane logic sees the live RAM data so the result can be
    // registered on the ack edge itself; afterwards it sees the captured word.
    assign word_in = (state == READ) ? ram_read_value : word_reg;

    load_store32 u_lanes (
        .address         (offset_reg),
        .funct3          (funct3_reg),
        .ram_read_value  (word_in),
        .store_value     (store_value_reg),
        .load_value      (load_value),
        .ram_store_value (ram_store_value)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            store_reg        <= 1'b0;
            funct3_reg       <= '0;
            offset_reg       <= '0;
            store_value_reg  <= '0;
            word_reg         <= '0;
            resp_valid       <= 1'b0;
            resp_efault      <= 1'b0;
            resp_load_value  <= '0;
            ram_address      <= '0;
            ram_read_enable  <= 1'b0;
            ram_write_enable <= 1'b0;
            ram_write_value  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_reg       <= req_store;
                        funct3_reg      <= req_funct3;
                        offset_reg      <= req_address[1:0];
                        store_value_reg <= req_store_value;
                        ram_address     <= req_address[ADDRESS_WIDTH-1:2];
                        if (fault) begin
                            state           <= RESP;
                            resp_valid      <= 1'b1;
                            resp_efault     <= 1'b1;
                            resp_load_value <= '0;
                        end else if (req_store && req_funct3 == LS_W) begin
                            state            <= WRITE;
                            ram_write_enable <= 1'b1;
                            ram_write_value  <= req_store_value;
                        end else begin
                            state           <= READ;
                            ram_read_enable <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (ram_ack) begin
                        word_reg        <= ram_read_value;
                        ram_read_enable <= 1'b0;
                        if (store_reg) begin
                            state            <= WRITE;
                            ram_write_enable <= 1'b1;
                            ram_write_value  <= ram_store_value;
                        end else begin
                            state           <= RESP;
                            resp_valid      <= 1'b1;
                            resp_efault     <= 1'b0;
                            resp_load_value <= load_value;
                        end
                    end
                end
                WRITE: begin
                    if (ram_ack) begin
                        ram_write_enable <= 1'b0;
                        state            <= RESP;
                        resp_valid       <= 1'b1;
                        resp_efault      <= 1'b0;
                        resp_load_value  <= '0;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state           <= IDLE;
                        resp_valid      <= 1'b0;
                        resp_efault     <= 1'b0;
                        resp_load_value <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level memory model, RAM responder with
// programmable ack delay, directed scenarios followed by random traffic.
module tb_load_store_unit;

    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_store;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_address;
    logic [31:0]   req_store_value;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_efault;
    logic [31:0]   resp_load_value;
    logic [AW-3:0] ram_address;
    logic          ram_read_enable;
    logic          ram_write_enable;
    logic [31:0]   ram_write_value;
    logic [31:0]   ram_read_value;
    logic          ram_ack;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0]  mem_bytes [0:1023];
    logic [31:0] ram_mem   [0:255];

    load_store_unit #(.ADDRESS_WIDTH(AW)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_store        (req_store),
        .req_funct3       (req_funct3),
        .req_address      (req_address),
        .req_store_value  (req_store_value),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_efault      (resp_efault),
        .resp_load_value  (resp_load_value),
        .ram_address      (ram_address),
        .ram_read_enable  (ram_read_enable),
        .ram_write_enable (ram_write_enable),
        .ram_write_value  (ram_write_value),
        .ram_read_value   (ram_read_value),
        .ram_ack          (ram_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic set_word(input int w, input logic [31:0] v);
        ram_mem[w] = v;
        for (int i = 0; i < 4; i++) mem_bytes[w*4 + i] = v[8*i +: 8];
    endtask

    // One complete transaction starting and ending at a negedge in IDLE.
    // d = strobe cycles per RAM access (1 = ack in first cycle); hold = cycles
    // the response is left pending before the consumer takes it.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] v, input int d, input int hold,
                           output logic [31:0] got_load, output logic [31:0] got_wdata,
                           output int got_lat);
        int size, base, rd_cyc, wr_cyc, reads, writes, cyc, exp_reads, exp_writes, exp_lat;
        logic fault, done;
        logic [31:0] exp_load, exp_word;

        size  = 1 << f3[1:0];
        base  = int'(a[9:0]);
        fault = (f3[1:0] == 2'b11) || (base % size != 0) || (f3[2] && (st || size == 4));
        exp_load = 32'd0;
        exp_word = 32'd0;
        if (!fault && !st) begin
            for (int i = 0; i < size; i++) exp_load |= 32'(mem_bytes[base + i]) << (8*i);
            if (!f3[2] && size < 4 && exp_load[8*size - 1])
                exp_load |= ~((32'd1 << (8*size)) - 32'd1);
        end
        if (!fault && st) begin
            for (int i = 0; i < size; i++) mem_bytes[base + i] = v[8*i +: 8];
            for (int i = 0; i < 4; i++) exp_word[8*i +: 8] = mem_bytes[(base & ~3) + i];
        end
        exp_reads  = (!fault && !(st && size == 4)) ? 1 : 0;
        exp_writes = (!fault && st) ? 1 : 0;
        exp_lat    = 1 + d * (exp_reads + exp_writes);

        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_address = a; req_store_value = v;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_address = $urandom; req_store_value = $urandom;

        cyc = 1; rd_cyc = 0; wr_cyc = 0; reads = 0; writes = 0; done = 1'b0;
        got_wdata = 32'd0;
        while (!done && cyc < 60) begin
            if (resp_valid) begin
                done = 1'b1;
            end else begin
                check("busy_req_ready", 32'(req_ready), 32'd0);
                check("strobe_exclusive", 32'(ram_read_enable & ram_write_enable), 32'd0);
                ram_ack = 1'b0;
                ram_read_value = $urandom;
                if (ram_read_enable) begin
                    rd_cyc++;
                    check("read_address", 32'(ram_address), 32'(a[31:2]));
                    if (rd_cyc == d) begin
                        ram_ack = 1'b1;
                        ram_read_value = ram_mem[ram_address[7:0]];
                        reads++;
                    end
                end else if (ram_write_enable) begin
                    wr_cyc++;
                    check("write_address", 32'(ram_address), 32'(a[31:2]));
                    check("write_value", ram_write_value, exp_word);
                    if (wr_cyc == d) begin
                        ram_ack = 1'b1;
                        ram_mem[ram_address[7:0]] = ram_write_value;
                        got_wdata = ram_write_value;
                        writes++;
                    end
                end
                @(posedge clock);
                @(negedge clock);
                cyc++;
            end
        end
        ram_ack = 1'b0;
        check("resp_arrived", 32'(resp_valid), 32'd1);
        got_lat  = cyc;
        got_load = resp_load_value;
        check("latency", 32'(cyc), 32'(exp_lat));
        check("efault", 32'(resp_efault), 32'(fault));
        check("load_value", resp_load_value, exp_load);
        check("read_count", 32'(reads), 32'(exp_reads));
        check("write_count", 32'(writes), 32'(exp_writes));

        for (int h = 0; h < hold; h++) begin
            ram_ack = 1'($urandom_range(0, 1));
            @(posedge clock);
            @(negedge clock);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_efault", 32'(resp_efault), 32'(fault));
            check("hold_load", resp_load_value, exp_load);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_strobes", 32'({ram_read_enable, ram_write_enable}), 32'd0);
        end
        ram_ack = 1'b0;
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        check("resp_drop", 32'(resp_valid), 32'd0);
        check("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] got_load, got_wdata, a, v;
        logic [2:0]  f3;
        logic        st;
        int          got_lat;

        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_address = '0; req_store_value = '0; resp_ready = 1'b0;
        ram_read_value = '0; ram_ack = 1'b0;
        for (int w = 0; w < 256; w++) set_word(w, $urandom);

        #12;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_efault", 32'(resp_efault), 32'd0);
        check("rst_load_value", resp_load_value, 32'd0);
        check("rst_strobes", 32'({ram_read_enable, ram_write_enable}), 32'd0);
        check("rst_ram_address", 32'(ram_address), 32'd0);
        check("rst_write_value", ram_write_value, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;

        set_word(0, 32'h456789ab);
        run_txn(1'b0, 3'b000, 32'h0000_1001, 32'd0, 1, 0, got_load, got_wdata, got_lat);
        check("lb_value", got_load, 32'hffffff89);
        check("lb_latency", 32'(got_lat), 32'd2);
        $display("lb  0x1001 -> 0x%08h lat %0d", got_load, got_lat);

        set_word(0, 32'h456789ab);
        run_txn(1'b0, 3'b101, 32'h0000_2002, 32'd0, 3, 1, got_load, got_wdata, got_lat);
        check("lhu_value", got_load, 32'h00004567);
        $display("lhu 0x2002 -> 0x%08h lat %0d", got_load, got_lat);

        set_word(0, 32'h456789ab);
        run_txn(1'b1, 3'b000, 32'h0000_0003, 32'hffffffff, 1, 0, got_load, got_wdata, got_lat);
        check("sb_wdata", got_wdata, 32'hff6789ab);
        check("sb_load_zero", got_load, 32'd0);
        check("sb_latency", 32'(got_lat), 32'd3);
        $display("sb  0x0003 -> wrote 0x%08h lat %0d", got_wdata, got_lat);

        run_txn(1'b1, 3'b010, 32'h0000_0010, 32'h12345678, 1, 0, got_load, got_wdata, got_lat);
        check("sw_ram_word", ram_mem[4], 32'h12345678);
        check("sw_latency", 32'(got_lat), 32'd2);
        $display("sw  0x0010 -> wrote 0x%08h lat %0d", got_wdata, got_lat);

        run_txn(1'b0, 3'b010, 32'h0000_0002, 32'd0, 1, 4, got_load, got_wdata, got_lat);
        check("lw_fault_latency", 32'(got_lat), 32'd1);
        $display("lw  0x0002 -> fault lat %0d", got_lat);
        run_txn(1'b1, 3'b100, 32'h0000_0000, 32'hdeadbeef, 1, 0, got_load, got_wdata, got_lat);
        check("st100_fault_latency", 32'(got_lat), 32'd1);
        $display("st funct3=100 -> fault lat %0d", got_lat);

        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b000;
        req_address = 32'h0000_1005; req_store_value = '0;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("mid_read_strobe", 32'(ram_read_enable), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_strobe", 32'(ram_read_enable), 32'd0);
        check("mid_rst_resp", 32'(resp_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        $display("reset during READ -> strobe %0b resp_valid %0b", ram_read_enable, resp_valid);
        run_txn(1'b0, 3'b000, 32'h0000_1005, 32'd0, 2, 0, got_load, got_wdata, got_lat);
        $display("lb  0x1005 after reset -> 0x%08h lat %0d", got_load, got_lat);

        for (int t = 0; t < 60; t++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            v  = $urandom;
            run_txn(st, f3, a, v, $urandom_range(1, 3), $urandom_range(0, 2),
                    got_load, got_wdata, got_lat);
            $display("rand %0d st=%0b f3=%03b a=0x%08h -> load 0x%08h wdata 0x%08h lat %0d",
                     t, st, f3, a, got_load, got_wdata, got_lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequential memory-access stage between the execute stage and a word-addressed 32-bit RAM port.
- Accepts one load/store request at a time and checks alignment.
- Loads: reads the containing word. Sub-word stores: read-modify-write. Aligned `sw`: direct write.
- Byte/half extraction and store-lane merging are delegated to the existing combinational `load_store32`; this block adds the handshakes, the FSM and the RAM sequencing.

Parameters:
- `ADDRESS_WIDTH`, 32, width of byte address; RAM word address is `ADDRESS_WIDTH-2` bits.

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept request
- `req_store`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV funct3: 000 b, 001 h, 010 w, bit2 = unsigned (loads only)
- `req_address`  in  ADDRESS_WIDTH  byte address
- `req_store_value`  in  32  store data (low bytes used for b/h)
- `resp_valid`  out  1  result present
- `resp_ready`  in  1  consumer takes result
- `resp_efault`  out  1  misaligned/illegal access; no RAM access was made
- `resp_load_value`  out  32  extended load result; 0 for stores and faults
- `ram_address`  out  ADDRESS_WIDTH-2  word address
- `ram_read_enable`  out  1  read strobe, held until `ram_ack`
- `ram_write_enable`  out  1  write strobe, held until `ram_ack`
- `ram_write_value`  out  32  full merged word
- `ram_read_value`  in  32  read data, valid in the cycle `ram_ack`=1 during READ
- `ram_ack`  in  1  RAM completes the current strobe this cycle

Behaviour:
- Reset:
  - Asynchronous reset; while `reset`=1, FSM forces IDLE and all registers clear.
  - Resulting reset values: `resp_valid`=0, `resp_efault`=0, `resp_load_value`=0, `ram_read_enable`=0, `ram_write_enable`=0, `ram_address`=0, `ram_write_value`=0.
  - `req_ready`=1 in IDLE.
- States: IDLE, READ, WRITE, RESP. `req_ready`=1 only in IDLE, so there is at most one request in flight.
- IDLE, on `req_valid` & `req_ready`: latch store flag, funct3, address, store value. Compute the fault:
  - `funct3[1:0]`=11 faults.
  - `funct3[1:0]`=01 faults when `addr[0]`=1.
  - `funct3[1:0]`=10 faults when `addr[1:0]`!=0 or `funct3[2]`=1.
  - A store with `funct3[2]`=1 also faults.
- IDLE next state:
  - fault -> RESP with `resp_efault`=1.
  - aligned `sw` (010, store) -> WRITE; `ram_write_value` = store value, no read.
  - otherwise -> READ.
- READ:
  - `ram_read_enable`=1, `ram_address` = `addr[ADDRESS_WIDTH-1:2]`.
  - On `ram_ack`, capture `ram_read_value` into the word register.
  - Load -> RESP; `resp_load_value` = `load_store32.load_value`.
  - Store -> WRITE; `ram_write_value` = `load_store32.ram_store_value`.
- WRITE: `ram_write_enable`=1, same address. On `ram_ack` -> RESP, `resp_load_value`=0.
- Strobe rules:
  - Read and write enables are never both high.
  - Strobes are registered (Moore) and stay stable with unchanged address/data until ack.
  - An ack arriving in the first strobe cycle is legal.
  - `ram_ack` outside READ/WRITE is ignored.
- RESP:
  - `resp_valid`=1; `resp_efault`/`resp_load_value` are held stable until `resp_valid` & `resp_ready`, then -> IDLE.
  - Accepting a new request in the same cycle is not allowed; `req_ready` rises the following cycle.
- Latency, ack in the first strobe cycle (accept edge = cycle 0, resp_valid visible in cycle N):
  - fault: `resp_valid` in cycle 1.
  - load / `sw`: cycle 2.
  - `sb`/`sh`: cycle 3.
  - Each extra RAM wait cycle adds 1.
- `load_store32` outputs are 'x under fault. They are never sampled in a faulting transaction; all registered outputs stay X-free.
- Reset mid-transaction: the transaction is dropped; no response; strobes drop asynchronously.

Decomposition:
- Package `load_store_pkg`:
  - `funct3` constants (`LS_B`=3'b000, `LS_H`=3'b001, `LS_W`=3'b010, `LS_UNSIGNED_BIT`=2).
  - `state_t` enum {IDLE, READ, WRITE, RESP}.
  - `function misaligned(funct3, addr[1:0], store)`.
- Sub-module: one instance of `load_store32`, fed by the latched address, latched funct3, captured RAM word and latched store value.

Test Plan:
- `lb` at addr 0x1001, RAM word 0x456789ab, ack after 1 cycle -> `ram_address`=0x400, one read, `resp_load_value`=0xffffff89, efault=0, `resp_valid` cycle 2.
- `lhu` at 0x2002, word 0x456789ab, ack delayed 3 cycles -> read strobe held 3 cycles with stable address; result 0x00004567.
- `sb` 0xffffffff at 0x0003, word 0x456789ab -> read then write; `ram_write_value`=0xff6789ab; `resp_load_value`=0; `resp_valid` cycle 3.
- `sw` 0x12345678 at 0x0010 -> no read strobe; write of 0x12345678 to word 0x4; `resp_valid` cycle 2.
- `lw` at 0x0002, and store with funct3=100 -> no RAM strobes; `resp_efault`=1 in cycle 1; then `resp_ready` held low 4 cycles -> outputs stable, `req_ready`=0 throughout.
- Assert `reset` while in READ -> strobe and `resp_valid` drop immediately; after release `req_ready`=1 and the next `lb` completes normally.
